serial_mult_ctrl: RTL and testbench

- Sequential shift-and-add unsigned multiplier controller that time-shares one external full_adder cell, bit-serially.
- Latches operands on a start pulse and walks multiplier bits, adding the shifted multiplicand one bit per cycle through the shared adder.
- Presents a registered product with a one-cycle done pulse.
- Serves as the area-minimal alternative to the combinational 3x3 array multiplier.

---
 rtl/serial_mult_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_serial_mult_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_mult_ctrl
// Brief    : Bit-serial shift-and-add unsigned multiplier controller. Walks
//            the multiplier bits row by row and, for every set bit, ripples
//            the shifted multiplicand into the accumulator one column per
//            cycle through a single external full_adder cell.
// Revision : 1.0 - initial release
// ============================================================================
module serial_mult_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 fa_a,
  output logic                 fa_b,
  output logic                 fa_cin,
  input  logic                 fa_sum,
  input  logic                 fa_cout,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // Counter widths: j and i must reach WIDTH; the column index j+i must
  // reach 2*WIDTH-1.
  localparam int PW = 2 * WIDTH;
  localparam int JW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(2 * WIDTH);

  localparam logic [JW-1:0]    c_W      = JW'(WIDTH);
  localparam logic [JW-1:0]    c_LAST_J = JW'(WIDTH - 1);
  localparam logic [JW-1:0]    c_ONE_J  = JW'(1);
  localparam logic [WIDTH-1:0] c_ONE_OP = WIDTH'(1);
  localparam logic [PW-1:0]    c_ONE_P  = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROW  = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [PW-1:0]     r_acc;
  logic [JW-1:0]     r_j;
  logic [JW-1:0]     r_i;
  logic              r_carry;
  logic [PW-1:0]     r_product;

  logic [CW-1:0]     w_col;
  logic [PW-1:0]     w_mask;
  logic              w_a_bit;
  logic              w_b_bit;
  logic              w_acc_bit;
  logic [PW-1:0]     w_acc_next;
  logic              w_last_row;
  logic              w_last_col;

  // Bit selects are done with one-hot masks so that an out-of-range index
  // (i == WIDTH, the final carry column) naturally yields a zero bit.
  assign w_col      = CW'(r_j) + CW'(r_i);
  assign w_mask     = c_ONE_P << w_col;
  assign w_a_bit    = |(r_a & (c_ONE_OP << r_i));
  assign w_b_bit    = |(r_b & (c_ONE_OP << r_j));
  assign w_acc_bit  = |(r_acc & w_mask);
  assign w_acc_next = fa_sum ? (r_acc | w_mask) : (r_acc & ~w_mask);
  assign w_last_row = (r_j == c_LAST_J);
  assign w_last_col = (r_i == c_W);
  assign product    = r_product;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and the adder/handshake outputs.
  always_comb begin
    w_state_next = r_state;
    fa_a         = 1'b0;
    fa_b         = 1'b0;
    fa_cin       = 1'b0;
    busy         = (r_state != S_IDLE);
    done         = (r_state == S_DONE);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_ROW;
        end
      end
      S_ROW: begin
        if (w_b_bit) begin
          w_state_next = S_ADD;
        end else if (w_last_row) begin
          w_state_next = S_DONE;
        end
      end
      S_ADD: begin
        fa_a   = w_a_bit;
        fa_b   = w_acc_bit;
        fa_cin = r_carry;
        if (w_last_col) begin
          w_state_next = w_last_row ? S_DONE : S_ROW;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand latch, row/column counters, carry and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_j     <= '0;
      r_i     <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_j     <= '0;
            r_i     <= '0;
            r_carry <= 1'b0;
          end
        end
        S_ROW: begin
          if (w_b_bit) begin
            r_i     <= '0;
            r_carry <= 1'b0;
          end else if (!w_last_row) begin
            r_j <= r_j + c_ONE_J;
          end
        end
        S_ADD: begin
          r_acc   <= w_acc_next;
          r_carry <= fa_cout;
          if (w_last_col) begin
            r_i <= '0;
            if (!w_last_row) begin
              r_j <= r_j + c_ONE_J;
            end
          end else begin
            r_i <= r_i + c_ONE_J;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Capture the final accumulator on entry to DONE; the last column write
  // lands on that same edge, so take the post-write value when leaving ADD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_product <= '0;
    end else if ((w_state_next == S_DONE) && (r_state != S_DONE)) begin
      r_product <= (r_state == S_ADD) ? w_acc_next : r_acc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_mult_ctrl
// Brief    : Self-checking bench for serial_mult_ctrl (WIDTH=3) with a
//            behavioural full adder, a cycle-level transaction model and
//            directed operand vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_mult_ctrl;

  localparam int W  = 3;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          fa_a, fa_b, fa_cin, fa_sum, fa_cout;
  logic          busy, done;
  logic [PW-1:0] product;

  int total = 0;
  int bad   = 0;

  serial_mult_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .fa_a    (fa_a),
    .fa_b    (fa_b),
    .fa_cin  (fa_cin),
    .fa_sum  (fa_sum),
    .fa_cout (fa_cout),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Shared full adder cell.
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted start makes the block busy, done appears
  // in cycle W + popcount(b)*(W+1) + 1, product becomes a*b there and holds.
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  int            m_left = 0;
  logic [PW-1:0] m_pend = '0;
  logic [PW-1:0] m_prod = '0;
  logic [W-1:0]  m_b    = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_prod <= '0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1;
        m_left <= W + $countones(b) * (W + 1);
        m_pend <= PW'(a) * PW'(b);
        m_b    <= b;
      end
    end else if (m_done) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (m_left == 1) begin
      m_done <= 1'b1;
      m_prod <= m_pend;
      m_left <= 0;
    end else begin
      m_left <= m_left - 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("busy", int'(busy), int'(m_busy));
    chk("done", int'(done), int'(m_done));
    chk("product", int'(product), int'(m_prod));
    if (!m_busy || m_done || (m_b == '0)) begin
      chk("fa_idle", int'({fa_a, fa_b, fa_cin}), 0);
    end
  end

  // One operation: start is raised in the cycle after the previous call
  // returned, and the done cycle is counted from the accepting edge.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input int exp_prod, input int exp_cyc,
                        input bit hold);
    int n;
    @(posedge clk);
    #1;
    a     = ta;
    b     = tb;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (done) break;
      if (n > 60) break;
    end
    start = 1'b0;
    chk("done_cycle", n, exp_cyc);
    chk("op_product", int'(product), exp_prod);
  endtask

  initial begin
    int n;
    // Reset held for three cycles, then idle with start low.
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_product", int'(product), 0);
    chk("rst_fa", int'({fa_a, fa_b, fa_cin}), 0);

    // Hand-computed directed vectors.
    run_op(3'd7, 3'd7, 49, 16, 1'b0);
    repeat (2) @(negedge clk);
    chk("hold_49", int'(product), 49);
    run_op(3'd5, 3'd0, 0, 4, 1'b0);
    run_op(3'd5, 3'd3, 15, 12, 1'b0);
    run_op(3'd2, 3'd4, 8, 8, 1'b0);
    run_op(3'd6, 3'd5, 30, 12, 1'b1);
    repeat (3) @(negedge clk);
    chk("no_restart_busy", int'(busy), 0);
    chk("hold_30", int'(product), 30);

    // Reset in the middle of an operation.
    @(posedge clk);
    #1;
    a = 3'd7; b = 3'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      n++;
    end
    chk("midop_busy_before", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midop_busy", int'(busy), 0);
    chk("midop_done", int'(done), 0);
    chk("midop_product", int'(product), 0);
    chk("midop_fa", int'({fa_a, fa_b, fa_cin}), 0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    run_op(3'd3, 3'd3, 9, 12, 1'b0);

    // All operand pairs against the arithmetic reference.
    for (int ia = 0; ia < 8; ia++) begin
      for (int ib = 0; ib < 8; ib++) begin
        run_op(W'(ia), W'(ib), ia * ib,
               W + $countones(W'(ib)) * (W + 1) + 1, 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
